stream_delay_adjust: RTL and testbench
======================================

# stream_delay_adjust

Runtime-adjustable AXI-stream sample delay/advance for the gmrr receive chain. It is the parametrised successor to the original single-mode delay block. It moves the stream's alignment by inserting fill samples or dropping input samples until the applied offset equals the requested `len`. Unlike the original, it selects hold-last or zero fill, regenerates packet boundaries from `max_spp`, preserves `tlast` across dropped samples, and allows `len` to change at any time, in either direction, repeatedly.

## Interface
- `WIDTH`, 16: sample width in bits.
- `MAX_LEN_LOG2`, 10: width of `len` and of the applied-offset counter.
- `SPP_W`, 16: width of `max_spp` and the output beat counter.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-high.
- `clear` in 1: synchronous; same effect as `reset`.
- `len` in MAX_LEN_LOG2: target offset in samples.
- `max_spp` in SPP_W: maximum output packet length; 0 disables splitting.
- `fill_mode` in 1: 0 = repeat last consumed sample, 1 = insert zeros.
- `i_tdata` in WIDTH, `i_tlast` in 1, `i_tvalid` in 1, `i_tready` out 1: input stream.
- `o_tdata` out WIDTH, `o_tlast` out 1, `o_tvalid` out 1, `o_tready` in 1: output stream.
- `delay_cur` out MAX_LEN_LOG2: applied offset `cur`.
- `busy` out 1: high in INSERT or DROP.

## Operation
- Registers:
  - `state`: IDLE, RUN, INSERT or DROP.
  - `cur`: applied offset.
  - `last_sample`: most recent consumed input sample.
  - `spp_cnt`: output beats since the last `o_tlast`.
  - `pend_last`: a dropped input beat carried `tlast`.
- Reset/clear values: state IDLE; `cur`, `last_sample`, `spp_cnt` and `pend_last` all 0. As a result `busy`=0, `delay_cur`=0, and the outputs behave as in the IDLE passthrough below.
- IDLE:
  - Passthrough: `o_tdata`=`i_tdata`, `o_tvalid`=`i_tvalid`, `i_tready`=`o_tready`.
  - The first transfer captures `last_sample` and moves to RUN.
  - `len` is ignored until then.
- RUN:
  - Same passthrough as IDLE; `last_sample` updates on every transfer.
  - Next state: INSERT if `len`>`cur`, DROP if `len`<`cur`, otherwise RUN.
  - A transfer in the same cycle as a state change completes normally.
- INSERT:
  - `i_tready`=0.
  - `o_tvalid`=(`cur`<`len`).
  - `o_tdata` = `last_sample` when `fill_mode`=0, else 0.
  - Each accepted output beat increments `cur`.
  - If `cur`>=`len` at a cycle start: no beat that cycle, return to RUN.
- DROP:
  - `o_tvalid`=0.
  - `i_tready`=(`cur`>`len`).
  - Each consumed beat decrements `cur` and updates `last_sample`.
  - A consumed beat with `tlast` sets `pend_last`.
  - If `cur`<=`len` at a cycle start: return to RUN.
- `len` may change mid-INSERT/DROP. The comparisons above are re-evaluated each cycle, so overshoot is impossible and `cur` never wraps.
- `o_tlast` is asserted on an output beat when any of these holds:
  - the beat is a passthrough beat and `i_tlast`=1;
  - `pend_last`=1;
  - `max_spp`!=0 and `spp_cnt`==`max_spp`-1.
- Fill beats never take `tlast` from input.
- `spp_cnt` increments on each output beat and resets to 0 on a beat with `o_tlast`.
- `pend_last` clears on the next output beat.

## Timing
- Passthrough latency is 0 cycles (combinational data and handshake paths); there are no bubbles in RUN.
- A `len` change takes effect at the next state decision: at most one further passthrough beat occurs before the first INSERT/DROP cycle.
- Returning to RUN costs one cycle with no transfer.
- In INSERT, exactly (`len`-`cur`) fill beats are produced, independent of `o_tready` stalls. The count reflects `len` at the final cycle if `len` changes mid-adjustment.
- `delay_cur` and `busy` are registered and valid the cycle after the change.
- Asserting `reset` mid-operation forces the reset values immediately. Any beat in progress is abandoned with no completion requirement.

## Test plan
- Passthrough:
  - Stimulus: `len`=0, `max_spp`=0; stream 0..99 with `tlast` on 99; `o_tready`=1.
  - Required: output identical with zero latency; `delay_cur`=0, `busy`=0 throughout.
- Insert, hold-last:
  - Stimulus: after inputs 1..10, set `len`=3 with `fill_mode`=0.
  - Required: exactly three fill beats of value 10 with `i_tready`=0 and `o_tlast`=0, then 11, 12, … pass through; `delay_cur`=3.
- Drop with `tlast` carry:
  - Stimulus: from `cur`=3, set `len`=1; the second dropped input beat has `tlast`.
  - Required: two inputs are consumed with `o_tvalid`=0; the next output beat has `o_tlast`=1; `delay_cur`=1.
- Repacketisation:
  - Stimulus: `max_spp`=8, `fill_mode`=1; `len` steps 0→4 inside a 16-sample input packet.
  - Required: output is 20 beats, including 4 zero fill beats; `o_tlast` appears on output beats 8, 16 and 20.
- Backpressure and live `len` change:
  - Stimulus: `len` 0→6 with `o_tready` toggling 50%; `len` changed to 2 after 3 fill beats are accepted.
  - Required: 3 fill beats only, then passthrough; `delay_cur`=3 → DROP of 1 beat → `delay_cur`=2.
- Reset and clear mid-operation:
  - Stimulus: asynchronous `reset` asserted mid-INSERT; separately, `clear` pulsed mid-DROP.
  - Required: after `reset`, state returns to IDLE immediately with `busy`=0 and `delay_cur`=0; `clear` has the same effect at the next clock edge; the next input passes through.

Source files
------------

// File: rtl/stream_delay_adjust.sv
// Runtime-adjustable stream delay/advance: inserts fill beats or drops input beats
// until the applied offset matches len, regenerating packet boundaries from max_spp.
module stream_delay_adjust #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned MAX_LEN_LOG2 = 10,
    parameter int unsigned SPP_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [MAX_LEN_LOG2-1:0] len,
    input  logic [SPP_W-1:0]        max_spp,
    input  logic                    fill_mode,
    input  logic [WIDTH-1:0]        i_tdata,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [WIDTH-1:0]        o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [MAX_LEN_LOG2-1:0] delay_cur,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, RUN, INSERT, DROP} state_t;

    state_t                  state, state_d;
    logic [MAX_LEN_LOG2-1:0] cur, cur_d;
    logic [WIDTH-1:0]        last_sample, last_sample_d;
    logic [SPP_W-1:0]        spp_cnt, spp_cnt_d;
    logic                    pend_last, pend_last_d;
    logic                    pt_last;
    logic                    spp_hit;

    assign delay_cur = cur;

    // State register and datapath registers; clear behaves as a synchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cur         <= '0;
            last_sample <= '0;
            spp_cnt     <= '0;
            pend_last   <= 1'b0;
            busy        <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            cur         <= '0;
            last_sample <= '0;
            spp_cnt     <= '0;
            pend_last   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            last_sample <= last_sample_d;
            spp_cnt     <= spp_cnt_d;
            pend_last   <= pend_last_d;
            busy        <= (state_d == INSERT) || (state_d == DROP);
        end
    end

    // Next-state, handshake steering and boundary regeneration
    always_comb begin
        state_d       = state;
        cur_d         = cur;
        last_sample_d = last_sample;
        spp_cnt_d     = spp_cnt;
        pend_last_d   = pend_last;
        o_tdata       = i_tdata;
        o_tvalid      = i_tvalid;
        i_tready      = o_tready;
        pt_last       = i_tlast;
        spp_hit       = (max_spp != '0) && (spp_cnt == max_spp - SPP_W'(1));

        case (state)
            IDLE: begin
                if (i_tvalid && o_tready) begin
                    last_sample_d = i_tdata;
                    state_d       = RUN;
                end
            end
            RUN: begin
                if (i_tvalid && o_tready) begin
                    last_sample_d = i_tdata;
                end
                if (len > cur) begin
                    state_d = INSERT;
                end else if (len < cur) begin
                    state_d = DROP;
                end
            end
            INSERT: begin
                i_tready = 1'b0;
                pt_last  = 1'b0;
                o_tvalid = (cur < len);
                o_tdata  = fill_mode ? '0 : last_sample;
                if (cur >= len) begin
                    state_d = RUN;
                end else if (o_tready) begin
                    cur_d = cur + MAX_LEN_LOG2'(1);
                end
            end
            DROP: begin
                o_tvalid = 1'b0;
                pt_last  = 1'b0;
                i_tready = (cur > len);
                if (cur <= len) begin
                    state_d = RUN;
                end else if (i_tvalid) begin
                    cur_d         = cur - MAX_LEN_LOG2'(1);
                    last_sample_d = i_tdata;
                    if (i_tlast) begin
                        pend_last_d = 1'b1;
                    end
                end
            end
        endcase

        o_tlast = o_tvalid && (pt_last || pend_last || spp_hit);

        // Output beat bookkeeping; DROP never has an output beat, so no clash with pend_last set
        if (o_tvalid && o_tready) begin
            spp_cnt_d   = o_tlast ? '0 : spp_cnt + SPP_W'(1);
            pend_last_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_delay_adjust.sv
// Directed bench for stream_delay_adjust: passthrough, insert, drop with tlast carry,
// repacketisation, backpressure with live len change, reset and clear mid-operation.
module tb_stream_delay_adjust;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [9:0]  len;
    logic [15:0] max_spp;
    logic        fill_mode;
    logic [15:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [15:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [9:0]  delay_cur;
    logic        busy;

    int total = 0;
    int bad   = 0;

    stream_delay_adjust #(
        .WIDTH(16),
        .MAX_LEN_LOG2(10),
        .SPP_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .len(len),
        .max_spp(max_spp),
        .fill_mode(fill_mode),
        .i_tdata(i_tdata),
        .i_tlast(i_tlast),
        .i_tvalid(i_tvalid),
        .i_tready(i_tready),
        .o_tdata(o_tdata),
        .o_tlast(o_tlast),
        .o_tvalid(o_tvalid),
        .o_tready(o_tready),
        .delay_cur(delay_cur),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic ev, input logic [15:0] ed, input logic el,
                        input logic er, input logic eb, input logic [9:0] edc);
        chk({tag, ".o_tvalid"}, 32'(o_tvalid), 32'(ev));
        if (ev) begin
            chk({tag, ".o_tdata"}, 32'(o_tdata), 32'(ed));
            chk({tag, ".o_tlast"}, 32'(o_tlast), 32'(el));
        end
        chk({tag, ".i_tready"}, 32'(i_tready), 32'(er));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".delay_cur"}, 32'(delay_cur), 32'(edc));
    endtask

    task automatic put(input logic v, input logic [15:0] d, input logic l, input logic r);
        i_tvalid = v;
        i_tdata  = d;
        i_tlast  = l;
        o_tready = r;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb;
        int ii;
        logic fillc;
        logic idlec;
        logic [9:0] edc;

        reset = 1'b1;
        clear = 1'b0;
        len = '0;
        max_spp = '0;
        fill_mode = 1'b0;
        put(1'b1, 16'h0055, 1'b0, 1'b1);
        look("rst", 1'b1, 16'h0055, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        reset = 1'b0;

        // passthrough 0..99
        for (int k = 0; k < 100; k++) begin
            put(1'b1, 16'(k), k == 99, 1'b1);
            look("pass", 1'b1, 16'(k), k == 99, 1'b1, 1'b0, 10'd0);
            adv();
        end

        // insert hold-last
        for (int k = 1; k <= 10; k++) begin
            put(1'b1, 16'(k), 1'b0, 1'b1);
            look("pass2", 1'b1, 16'(k), 1'b0, 1'b1, 1'b0, 10'd0);
            adv();
        end
        len = 10'd3;
        put(1'b0, 16'd11, 1'b0, 1'b1);
        look("ins_dec", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        for (int f = 0; f < 3; f++) begin
            put(1'b1, 16'd11, 1'b0, 1'b1);
            look("fill", 1'b1, 16'd10, 1'b0, 1'b0, 1'b1, 10'(f));
            adv();
        end
        put(1'b1, 16'd11, 1'b0, 1'b1);
        look("ins_end", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 10'd3);
        adv();
        for (int k = 11; k <= 13; k++) begin
            put(1'b1, 16'(k), 1'b0, 1'b1);
            look("pass3", 1'b1, 16'(k), 1'b0, 1'b1, 1'b0, 10'd3);
            adv();
        end

        // drop with tlast carry
        len = 10'd1;
        put(1'b0, 16'd14, 1'b0, 1'b1);
        look("drop_dec", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd3);
        adv();
        put(1'b1, 16'd14, 1'b0, 1'b1);
        look("drop1", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 10'd3);
        adv();
        put(1'b1, 16'd15, 1'b1, 1'b1);
        look("drop2", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 10'd2);
        adv();
        put(1'b1, 16'd16, 1'b0, 1'b1);
        look("drop_end", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 10'd1);
        adv();
        put(1'b1, 16'd16, 1'b0, 1'b1);
        look("carry", 1'b1, 16'd16, 1'b1, 1'b1, 1'b0, 10'd1);
        adv();
        put(1'b1, 16'd17, 1'b0, 1'b1);
        look("carry_clr", 1'b1, 16'd17, 1'b0, 1'b1, 1'b0, 10'd1);
        adv();

        // clear back to IDLE, then repacketisation with zero fill
        clear = 1'b1;
        put(1'b0, 16'd0, 1'b0, 1'b1);
        look("pre_clr", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd1);
        adv();
        clear = 1'b0;
        max_spp = 16'd8;
        fill_mode = 1'b1;
        len = 10'd0;
        nb = 0;
        ii = 1;
        for (int c = 0; c <= 20; c++) begin
            if (c == 5) len = 10'd4;
            fillc = (c >= 6) && (c <= 9);
            idlec = (c == 10);
            if (!idlec) nb++;
            edc = (c <= 6) ? 10'd0 : (c >= 10) ? 10'd4 : 10'(c - 6);
            put(1'b1, 16'(ii), ii == 16, 1'b1);
            look("repack", !idlec, fillc ? 16'd0 : 16'(ii), (nb == 8) || (nb == 16) || (nb == 20),
                 !(fillc || idlec), (c >= 6) && (c <= 10), edc);
            adv();
            if (!(fillc || idlec)) ii++;
        end

        // clear mid-DROP
        max_spp = '0;
        fill_mode = 1'b0;
        len = 10'd0;
        put(1'b0, 16'd17, 1'b0, 1'b1);
        look("d_dec", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd4);
        adv();
        put(1'b1, 16'd17, 1'b0, 1'b1);
        look("d1", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 10'd4);
        adv();
        clear = 1'b1;
        put(1'b0, 16'd18, 1'b0, 1'b1);
        look("d_clr", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 10'd3);
        adv();
        clear = 1'b0;
        put(1'b1, 16'd18, 1'b0, 1'b1);
        look("post_clr", 1'b1, 16'd18, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();

        // backpressure with live len change 6 -> 2
        len = 10'd6;
        put(1'b0, 16'd19, 1'b0, 1'b1);
        look("bp_dec", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        for (int j = 0; j < 6; j++) begin
            put(1'b1, 16'd19, 1'b0, (j % 2) == 1);
            look("bp_fill", 1'b1, 16'd18, 1'b0, 1'b0, 1'b1, 10'(j / 2));
            adv();
        end
        len = 10'd2;
        put(1'b1, 16'd19, 1'b0, 1'b1);
        look("bp_end", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 10'd3);
        adv();
        put(1'b1, 16'd19, 1'b0, 1'b1);
        look("bp_pass", 1'b1, 16'd19, 1'b0, 1'b1, 1'b0, 10'd3);
        adv();
        put(1'b1, 16'd20, 1'b0, 1'b1);
        look("bp_drop", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 10'd3);
        adv();
        put(1'b1, 16'd21, 1'b0, 1'b1);
        look("bp_dend", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 10'd2);
        adv();
        put(1'b1, 16'd21, 1'b0, 1'b0);
        look("bp_stall", 1'b1, 16'd21, 1'b0, 1'b0, 1'b0, 10'd2);
        adv();
        put(1'b1, 16'd21, 1'b0, 1'b1);
        look("bp_run", 1'b1, 16'd21, 1'b0, 1'b1, 1'b0, 10'd2);
        adv();

        // asynchronous reset mid-INSERT
        len = 10'd5;
        put(1'b0, 16'd22, 1'b0, 1'b1);
        look("r_dec", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd2);
        adv();
        put(1'b1, 16'd22, 1'b0, 1'b1);
        look("r_fill", 1'b1, 16'd21, 1'b0, 1'b0, 1'b1, 10'd2);
        #2;
        reset = 1'b1;
        #1;
        look("r_async", 1'b1, 16'd22, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        reset = 1'b0;
        put(1'b1, 16'd22, 1'b0, 1'b1);
        look("r_idle", 1'b1, 16'd22, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        put(1'b0, 16'd23, 1'b0, 1'b1);
        look("r_run", 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 10'd0);
        adv();
        put(1'b1, 16'd23, 1'b0, 1'b1);
        look("r_refill", 1'b1, 16'd22, 1'b0, 1'b0, 1'b1, 10'd0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
